elastic_storage_bank: RTL

// - Next-generation elastic-buffer storage for the PCIe 5.0 RX MAC. Runs in the recovered-clock (rx_clk) write domain.
// - Accepts WR_SYMBOLS entries per cycle. A per-slot keep mask drops SKP symbols; kept entries are compacted into the

---
 rtl/eb_pkg.sv | 41 ++++
 rtl/eb_write_compactor.sv | 21 ++
 rtl/elastic_storage_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/eb_pkg.sv
// Shared types and helpers for the elastic-buffer storage bank.
package eb_pkg;

  localparam int SYMBOL_WIDTH = 8;
  localparam int COUNT_WIDTH  = 4;
  localparam int ENTRY_WIDTH  = COUNT_WIDTH + 1 + SYMBOL_WIDTH;

  // Helper widths: pointers up to 16 bits, up to 4 write slots per cycle.
  localparam int PTR_MAX_W = 16;
  localparam int KEEP_MAX  = 4;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic [COUNT_WIDTH-1:0]  count;
    logic                    block_type;
    logic [SYMBOL_WIDTH-1:0] symbol;
  } eb_entry_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/eb_write_compactor.sv
// Turns the per-slot keep mask into compacted write offsets: each kept slot
// lands at wr_ptr plus the number of kept slots below it.
module eb_write_compactor #(
  parameter int WR_SYMBOLS = 2
) (
  input  logic [WR_SYMBOLS-1:0]                   keep,
  output logic [WR_SYMBOLS-1:0][eb_pkg::CNT_W-1:0] offset,
  output logic [WR_SYMBOLS-1:0]                   we
);
  import eb_pkg::*;

  // Prefix sum of the keep bits strictly below each slot.
  always_comb begin
    offset = '0;
    we     = keep;
    for (int i = 0; i < WR_SYMBOLS; i++) begin
      offset[i] = popcount(KEEP_MAX'(keep) & KEEP_MAX'((1 << i) - 1));
    end
  end

endmodule

// File: rtl/elastic_storage_bank.sv
// Write-domain storage of the RX elastic buffer: compacts kept symbols into
// memory, owns the write pointer (binary + Gray), tracks fill and overflow,
// and exposes a combinational read port for the read-side controller.
module elastic_storage_bank #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int COUNT_WIDTH  = 4,
  parameter int DEPTH        = 16,
  parameter int WR_SYMBOLS   = 2,
  parameter int ENTRY_WIDTH  = COUNT_WIDTH + 1 + SYMBOL_WIDTH,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                              rx_clk,
  input  logic                              rx_rst,
  input  logic                              LTSSM_rst,
  input  logic                              elstc_buff_en,
  input  logic                              wr_valid,
  input  logic [WR_SYMBOLS*ENTRY_WIDTH-1:0] wr_data,
  input  logic [WR_SYMBOLS-1:0]             wr_keep,
  input  logic [ADDR_WIDTH:0]               rd_ptr_gray_sync,
  input  logic [ADDR_WIDTH-1:0]             raddr,
  input  logic                              empty,
  output logic [SYMBOL_WIDTH-1:0]           output_symbol,
  output logic                              block_type,
  output logic [COUNT_WIDTH-1:0]            count,
  output logic                              valid,
  output logic [ADDR_WIDTH:0]               wr_ptr_gray,
  output logic [ADDR_WIDTH:0]               fill_level,
  output logic                              full,
  output logic                              overflow
);
  import eb_pkg::*;

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          wr_ptr_next;
  logic [PW-1:0]          rd_bin;
  logic [CW-1:0]          free_space;
  logic [CNT_W-1:0]       n_kept;
  logic                   accept;
  logic                   fits;
  logic                   do_write;
  logic                   reject;
  logic [ENTRY_WIDTH-1:0] rd_entry;

  logic [WR_SYMBOLS-1:0][CNT_W-1:0]      slot_off;
  logic [WR_SYMBOLS-1:0]                 slot_we;
  logic [WR_SYMBOLS-1:0][ADDR_WIDTH-1:0] slot_addr;

  eb_write_compactor #(
    .WR_SYMBOLS (WR_SYMBOLS)
  ) u_compactor (
    .keep   (wr_keep),
    .offset (slot_off),
    .we     (slot_we)
  );

  // Space check, write decision, slot addresses and next pointer.
  always_comb begin
    rd_bin      = PW'(gray2bin(PTR_MAX_W'(rd_ptr_gray_sync)));
    fill_level  = wr_ptr - rd_bin;
    full        = fill_level > PW'(DEPTH - WR_SYMBOLS);
    free_space  = CW'(DEPTH) - CW'(fill_level);
    n_kept      = popcount(KEEP_MAX'(wr_keep));
    accept      = wr_valid & elstc_buff_en & ~LTSSM_rst;
    fits        = CW'(n_kept) <= free_space;
    do_write    = accept & (n_kept != '0) & fits;
    reject      = accept & ~fits;
    wr_ptr_next = do_write ? wr_ptr + PW'(n_kept) : wr_ptr;
    slot_addr   = '0;
    for (int i = 0; i < WR_SYMBOLS; i++) begin
      slot_addr[i] = wr_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(slot_off[i]);
    end
  end

  // Write pointer, its Gray image and the sticky overflow flag.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      overflow    <= 1'b0;
    end else if (LTSSM_rst) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      wr_ptr_gray <= PW'(bin2gray(PTR_MAX_W'(wr_ptr_next)));
      if (reject) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array: cleared on either reset, otherwise all-or-nothing slot writes.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else if (LTSSM_rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else if (do_write) begin
      for (int i = 0; i < WR_SYMBOLS; i++) begin
        if (slot_we[i]) begin
          mem[slot_addr[i]] <= wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
      end
    end
  end

  // Combinational read port, no latency.
  always_comb begin
    rd_entry      = mem[raddr];
    output_symbol = rd_entry[SYMBOL_WIDTH-1:0];
    block_type    = rd_entry[SYMBOL_WIDTH];
    count         = rd_entry[ENTRY_WIDTH-1 -: COUNT_WIDTH];
    valid         = ~empty;
  end

endmodule
